// File: rtl/buffer_fifo.sv
// Synchronous FIFO over a simple dual-port RAM with registered flags, a level count,
// and a sticky overflow flag backed by a saturating drop counter.
module buffer_fifo #(
    parameter int AW          = 8,
    parameter int DW          = 8,
    parameter int AFULL_LEVEL = 2**AW - 4,
    parameter int CW          = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          write_enable,
    input  logic [DW-1:0] write_data,
    input  logic          read_enable,
    output logic [DW-1:0] read_data,
    output logic          read_valid,
    output logic          empty,
    output logic          full,
    output logic          almost_full,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic [CW-1:0] drop_count,
    input  logic          clear_overflow
);

    localparam logic [AW:0] DEPTH   = (AW+1)'(2**AW);
    localparam logic [AW:0] AFULL_L = (AW+1)'(AFULL_LEVEL);

    logic [DW-1:0] mem [2**AW];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          afull_q, afull_d;
    logic [DW-1:0] read_data_q, read_data_d;
    logic          read_valid_q, read_valid_d;
    logic          overflow_q, overflow_d;
    logic [CW-1:0] drop_count_q, drop_count_d;

    logic pop, push, drop;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a push alongside it.
    assign pop  = read_enable && !empty_q;
    assign push = write_enable && (!full_q || pop);
    assign drop = write_enable && full_q && !pop;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        read_data_d  = read_data_q;
        read_valid_d = 1'b0;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop) begin
            rd_ptr_d     = rd_ptr_q + 1'b1;
            read_data_d  = mem[rd_ptr_q];
            read_valid_d = 1'b1;
        end

        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        // A drop in the same cycle as a clear leaves exactly that one drop recorded.
        if (clear_overflow) begin
            overflow_d   = 1'b0;
            drop_count_d = '0;
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (clear_overflow)        drop_count_d = CW'(1);
            else if (drop_count_q != '1) drop_count_d = drop_count_q + 1'b1;
        end

        empty_d = (level_d == '0);
        full_d  = (level_d == DEPTH);
        afull_d = (level_d >= AFULL_L);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            empty_q      <= 1'b1;
            full_q       <= 1'b0;
            afull_q      <= 1'b0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            empty_q      <= empty_d;
            full_q       <= full_d;
            afull_q      <= afull_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    // NOTE: the RAM array has no reset so it maps onto block memory; the pointers alone define validity.
    always_ff @(posedge clock) begin
        if (push && !reset) mem[wr_ptr_q] <= write_data;
    end

    assign read_data   = read_data_q;
    assign read_valid  = read_valid_q;
    assign empty       = empty_q;
    assign full        = full_q;
    assign almost_full = afull_q;
    assign level       = level_q;
    assign overflow    = overflow_q;
    assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_buffer_fifo.sv
// Directed bench for buffer_fifo: a vector table for short sequences plus hand-written
// fill/drain, overflow and reset-while-busy sequences.
module tb_buffer_fifo;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int CW = 16;
    localparam int DEPTH = 2**AW;
    localparam int AFULL = DEPTH - 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          write_enable;
    logic [DW-1:0] write_data;
    logic          read_enable;
    logic [DW-1:0] read_data;
    logic          read_valid;
    logic          empty;
    logic          full;
    logic          almost_full;
    logic [AW:0]   level;
    logic          overflow;
    logic [CW-1:0] drop_count;
    logic          clear_overflow;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    buffer_fifo #(.AW(AW), .DW(DW), .AFULL_LEVEL(AFULL), .CW(CW)) dut (
        .clock          (clock),
        .reset          (reset),
        .write_enable   (write_enable),
        .write_data     (write_data),
        .read_enable    (read_enable),
        .read_data      (read_data),
        .read_valid     (read_valid),
        .empty          (empty),
        .full           (full),
        .almost_full    (almost_full),
        .level          (level),
        .overflow       (overflow),
        .drop_count     (drop_count),
        .clear_overflow (clear_overflow)
    );

    typedef struct {
        logic          rst;
        logic          we;
        logic [DW-1:0] wd;
        logic          re;
        logic          clr;
        logic [DW-1:0] rd;
        logic          rv;
        int            lvl;
        logic          ovf;
        int            drops;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic we, input logic [DW-1:0] wd,
                         input logic re, input logic clr);
        reset          = r;
        write_enable   = we;
        write_data     = wd;
        read_enable    = re;
        clear_overflow = clr;
    endtask

    // Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_flags(input string tag, input int lvl);
        check({tag, ".level"}, 32'(level), 32'(lvl));
        check({tag, ".empty"}, 32'(empty), 32'(lvl == 0));
        check({tag, ".full"}, 32'(full), 32'(lvl == DEPTH));
        check({tag, ".afull"}, 32'(almost_full), 32'(lvl >= AFULL));
    endtask

    task automatic fill_sequential();
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 1, DW'(i), 0, 0);
            step();
            check_flags($sformatf("fill%0d", i), i + 1);
        end
        drive(0, 0, 0, 0, 0);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0);

        //           rst we  wd     re clr  rd     rv lvl ovf drops
        vecs[0]  = '{1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0};
        vecs[1]  = '{0, 1, 8'hF1, 0, 0, 8'h00, 0, 1, 0, 0};
        vecs[2]  = '{0, 0, 8'h00, 1, 0, 8'hF1, 1, 0, 0, 0};
        vecs[3]  = '{0, 0, 8'h00, 1, 0, 8'hF1, 0, 0, 0, 0};
        vecs[4]  = '{0, 0, 8'h00, 0, 0, 8'hF1, 0, 0, 0, 0};
        vecs[5]  = '{0, 1, 8'hA5, 1, 0, 8'hF1, 0, 1, 0, 0};
        vecs[6]  = '{0, 1, 8'h3C, 0, 0, 8'hF1, 0, 2, 0, 0};
        vecs[7]  = '{0, 1, 8'h77, 1, 0, 8'hA5, 1, 2, 0, 0};
        vecs[8]  = '{0, 0, 8'h00, 1, 0, 8'h3C, 1, 1, 0, 0};
        vecs[9]  = '{0, 0, 8'h00, 1, 0, 8'h77, 1, 0, 0, 0};
        vecs[10] = '{0, 0, 8'h00, 0, 1, 8'h77, 0, 0, 0, 0};

        for (int v = 0; v < 11; v++) begin
            drive(vecs[v].rst, vecs[v].we, vecs[v].wd, vecs[v].re, vecs[v].clr);
            step();
            check($sformatf("v%0d.read_data", v), 32'(read_data), 32'(vecs[v].rd));
            check($sformatf("v%0d.read_valid", v), 32'(read_valid), 32'(vecs[v].rv));
            check_flags($sformatf("v%0d", v), vecs[v].lvl);
            check($sformatf("v%0d.overflow", v), 32'(overflow), 32'(vecs[v].ovf));
            check($sformatf("v%0d.drop_count", v), 32'(drop_count), 32'(vecs[v].drops));
        end

        // Fill to capacity from a fresh reset, watching almost_full rise at 252.
        drive(1, 0, 0, 0, 0);
        step();
        fill_sequential();

        // Three dropped pushes while full: contents and level untouched.
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 8'hEE, 0, 0);
            step();
            check($sformatf("drop%0d.overflow", i), 32'(overflow), 32'd1);
            check($sformatf("drop%0d.drop_count", i), 32'(drop_count), 32'(i + 1));
            check_flags($sformatf("drop%0d", i), DEPTH);
        end

        // Push and pop together while full: the write lands on the slot just read.
        drive(0, 1, 8'hAB, 1, 0);
        step();
        check("fullpp.read_data", 32'(read_data), 32'h00);
        check("fullpp.read_valid", 32'(read_valid), 32'd1);
        check_flags("fullpp", DEPTH);

        // Drain across the pointer wrap: 0x01..0xFF then 0xAB.
        for (int i = 1; i <= DEPTH; i++) begin
            drive(0, 0, 0, 1, 0);
            step();
            check($sformatf("drain%0d.read_data", i), 32'(read_data),
                  (i == DEPTH) ? 32'hAB : 32'(i));
            check($sformatf("drain%0d.read_valid", i), 32'(read_valid), 32'd1);
            check_flags($sformatf("drain%0d", i), DEPTH - i);
        end
        drive(0, 0, 0, 1, 0);
        step();
        check("drained.read_valid", 32'(read_valid), 32'd0);
        check("drained.read_data", 32'(read_data), 32'hAB);

        // Clear coinciding with a drop: the drop wins and counts from one.
        fill_sequential();
        drive(0, 1, 8'hEE, 0, 1);
        step();
        check("clrdrop.overflow", 32'(overflow), 32'd1);
        check("clrdrop.drop_count", 32'(drop_count), 32'd1);
        check_flags("clrdrop", DEPTH);
        drive(0, 0, 0, 0, 1);
        step();
        check("clr.overflow", 32'(overflow), 32'd0);
        check("clr.drop_count", 32'(drop_count), 32'd0);

        // Reset while busy: 10 queued, read_data non-zero, pop requested on the reset edge.
        drive(1, 0, 0, 0, 0);
        step();
        for (int i = 0; i < 11; i++) begin
            drive(0, 1, DW'(8'h50 + i), 0, 0);
            step();
        end
        drive(0, 0, 0, 1, 0);
        step();
        check("prerst.read_data", 32'(read_data), 32'h50);
        check_flags("prerst", 10);
        drive(1, 0, 0, 1, 0);
        step();
        check("rst.read_valid", 32'(read_valid), 32'd0);
        check("rst.read_data", 32'(read_data), 32'h00);
        check("rst.overflow", 32'(overflow), 32'd0);
        check_flags("rst", 0);
        drive(0, 0, 0, 1, 0);
        step();
        check("postrst.read_valid", 32'(read_valid), 32'd0);
        check_flags("postrst", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
